// File: rtl/seven_seg_pkg.sv
// Shared segment constants and the BCD/hex glyph decode for seven_segment_decoder.
// Define SEVEN_SEG_HEX_DIGITS_EN to decode 10..15 as hex glyphs instead of blanking.
package seven_seg_pkg;

    localparam int unsigned SEG_W = 7;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam logic [SEG_W-1:0] SEG_BLANK  = 7'b000_0000;
    localparam logic [SEG_W-1:0] SEG_ALL_ON = 7'b111_1111;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Active-high glyph for one code; anything unlisted (including X) blanks.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] code);
        logic [SEG_W-1:0] s;
        s = SEG_BLANK;
        case (code)
            4'd0:    s = 7'b011_1111;
            4'd1:    s = 7'b000_0110;
            4'd2:    s = 7'b101_1011;
            4'd3:    s = 7'b100_1111;
            4'd4:    s = 7'b110_0110;
            4'd5:    s = 7'b110_1101;
            4'd6:    s = 7'b111_1101;
            4'd7:    s = 7'b000_0111;
            4'd8:    s = 7'b111_1111;
            4'd9:    s = 7'b110_1111;
`ifdef SEVEN_SEG_HEX_DIGITS_EN
            4'd10:   s = 7'b111_0111;
            4'd11:   s = 7'b111_1100;
            4'd12:   s = 7'b011_1001;
            4'd13:   s = 7'b101_1110;
            4'd14:   s = 7'b111_1001;
            4'd15:   s = 7'b111_0001;
`endif
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational BCD to 7-segment decode with lamp-test/blank overrides and a sticky
// illegal-code flag. SEVEN_SEG_HEX_DIGITS_EN makes all 16 codes legal hex glyphs.
module seven_segment_decoder
    import seven_seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       num,
    input  logic             lamp_test,
    input  logic             blank,
    input  logic             err_clr,
    output logic [SEG_W-1:0] seg,
    output logic             err
);

    logic [SEG_W-1:0] seg_hi;
    logic             err_set;
    logic             err_d;
    logic             err_q;

    always_comb begin
        seg_hi = seg_decode(num);
        if (lamp_test) begin
            seg_hi = SEG_ALL_ON;
        end else if (blank) begin
            seg_hi = SEG_BLANK;
        end
        seg = ACTIVE_LOW ? ~seg_hi : seg_hi;
    end

    // Only a displayed code counts as illegal; overridden digits are never reported.
`ifdef SEVEN_SEG_HEX_DIGITS_EN
    assign err_set = 1'b0;
`else
    assign err_set = (num > BCD_MAX) && !blank && !lamp_test;
`endif

    always_comb begin
        err_d = err_q;
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Self-checking bench: two decoder instances (active-high and active-low) on shared inputs.
module tb_seven_segment_decoder;

`ifdef SEVEN_SEG_HEX_DIGITS_EN
    localparam bit HEX = 1'b1;
`else
    localparam bit HEX = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] num = 4'd1;
    logic       lamp_test = 1'b0;
    logic       blank = 1'b0;
    logic       err_clr = 1'b0;
    logic [6:0] seg_ah, seg_al;
    logic       err_ah, err_al;

    int tests = 0;
    int fails = 0;
    logic err_m = 1'b0;

    seven_segment_decoder #(.ACTIVE_LOW(1'b0)) u_dut_ah (
        .clk(clk), .rst_n(rst_n), .num(num), .lamp_test(lamp_test), .blank(blank),
        .err_clr(err_clr), .seg(seg_ah), .err(err_ah)
    );

    seven_segment_decoder #(.ACTIVE_LOW(1'b1)) u_dut_al (
        .clk(clk), .rst_n(rst_n), .num(num), .lamp_test(lamp_test), .blank(blank),
        .err_clr(err_clr), .seg(seg_al), .err(err_al)
    );

    always #5 clk = ~clk;

    // Glyphs described by which lettered segments light, 'a' = bit 0.
    function automatic logic [6:0] letters(input string s);
        logic [6:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
        return r;
    endfunction

    function automatic logic [6:0] model_seg(input int n, input logic lt, input logic bl);
        string digit_glyph[10];
        string hex_glyph[6];
        digit_glyph = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
        hex_glyph   = '{"abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
        if (lt) return 7'h7f;
        if (bl) return 7'h00;
        if (n <= 9) return letters(digit_glyph[n]);
        if (HEX) return letters(hex_glyph[n-10]);
        return 7'h00;
    endfunction

    // One rising edge with the err model advanced from the inputs held across it.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) err_m = 1'b0;
        else if (!HEX && num > 9 && !blank && !lamp_test) err_m = 1'b1;
        else if (err_clr) err_m = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if (err_ah !== 1'b0 || err_al !== 1'b0) begin
            $display("FAIL reset_err got %b/%b exp 0", err_ah, err_al); fails++;
        end
        tests++;
        if (seg_ah !== 7'b0000110) begin
            $display("FAIL reset_seg got %b exp 0000110", seg_ah); fails++;
        end
        #5 rst_n = 1'b1;
        err_m = 1'b0;
    endtask

    task automatic test_sweep();
        logic [6:0] e;
        for (int n = 0; n < 10; n++) begin
            num = 4'(n);
            #1;
            e = model_seg(n, 1'b0, 1'b0);
            tests++;
            if (seg_ah !== e) begin
                $display("FAIL sweep_ah num=%0d got %b exp %b", n, seg_ah, e); fails++;
            end
            tests++;
            if (seg_al !== ~e) begin
                $display("FAIL sweep_al num=%0d got %b exp %b", n, seg_al, ~e); fails++;
            end
        end
    endtask

    task automatic test_err_sequence();
        num = 4'd10; blank = 1'b0; lamp_test = 1'b0; err_clr = 1'b0;
        #1;
        tests++;
        if (seg_ah !== model_seg(10, 1'b0, 1'b0)) begin
            $display("FAIL code10_seg got %b exp %b", seg_ah, model_seg(10, 1'b0, 1'b0)); fails++;
        end
        tick();
        tests++;
        if (err_ah !== (HEX ? 1'b0 : 1'b1)) begin
            $display("FAIL err_set got %b exp %b", err_ah, ~HEX); fails++;
        end
        num = 4'd3;
        tick();
        tests++;
        if (err_ah !== err_m || err_al !== err_m) begin
            $display("FAIL err_sticky got %b/%b exp %b", err_ah, err_al, err_m); fails++;
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tests++;
        if (err_ah !== 1'b0) begin
            $display("FAIL err_clear got %b exp 0", err_ah); fails++;
        end
        // set beats clear on the same edge
        num = 4'd12; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tests++;
        if (err_ah !== err_m) begin
            $display("FAIL err_set_wins got %b exp %b", err_ah, err_m); fails++;
        end
        err_clr = 1'b1; num = 4'd0;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_priority();
        num = 4'd4; blank = 1'b1; lamp_test = 1'b1;
        #1;
        tests++;
        if (seg_ah !== 7'b1111111 || seg_al !== 7'b0000000) begin
            $display("FAIL prio_lamp got %b/%b exp 1111111/0000000", seg_ah, seg_al); fails++;
        end
        lamp_test = 1'b0;
        #1;
        tests++;
        if (seg_ah !== 7'b0000000 || seg_al !== 7'b1111111) begin
            $display("FAIL prio_blank got %b/%b exp 0000000/1111111", seg_ah, seg_al); fails++;
        end
        blank = 1'b0;
        #1;
        tests++;
        if (seg_ah !== 7'b1100110) begin
            $display("FAIL prio_decode got %b exp 1100110", seg_ah); fails++;
        end
        // masked illegal code must not raise err
        num = 4'd13; blank = 1'b1;
        tick();
        tests++;
        if (err_ah !== 1'b0) begin
            $display("FAIL blank_masks_err got %b exp 0", err_ah); fails++;
        end
        blank = 1'b0; num = 4'd0;
    endtask

    task automatic test_active_low();
        num = 4'd0;
        #1;
        tests++;
        if (seg_al !== 7'b1000000) begin
            $display("FAIL al_zero got %b exp 1000000", seg_al); fails++;
        end
        blank = 1'b1;
        #1;
        tests++;
        if (seg_al !== 7'b1111111) begin
            $display("FAIL al_blank got %b exp 1111111", seg_al); fails++;
        end
        blank = 1'b0;
    endtask

    task automatic test_upper_codes();
        logic [6:0] e;
        for (int n = 10; n < 16; n++) begin
            num = 4'(n);
            #1;
            e = model_seg(n, 1'b0, 1'b0);
            tests++;
            if (seg_ah !== e || seg_al !== ~e) begin
                $display("FAIL upper num=%0d got %b exp %b", n, seg_ah, e); fails++;
            end
            tick();
            tests++;
            if (err_ah !== err_m) begin
                $display("FAIL upper_err num=%0d got %b exp %b", n, err_ah, err_m); fails++;
            end
        end
        err_clr = 1'b1; num = 4'd0;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_random();
        logic [6:0] e;
        for (int i = 0; i < 300; i++) begin
            num       = 4'($urandom_range(0, 15));
            lamp_test = ($urandom_range(0, 7) == 0);
            blank     = ($urandom_range(0, 5) == 0);
            err_clr   = ($urandom_range(0, 3) == 0);
            #1;
            e = model_seg(int'(num), lamp_test, blank);
            tests++;
            if (seg_ah !== e || seg_al !== ~e) begin
                $display("FAIL rand_seg i=%0d num=%0d lt=%b bl=%b got %b/%b exp %b", i, num, lamp_test, blank, seg_ah, seg_al, e);
                fails++;
            end
            tick();
            tests++;
            if (err_ah !== err_m || err_al !== err_m) begin
                $display("FAIL rand_err i=%0d got %b/%b exp %b", i, err_ah, err_al, err_m); fails++;
            end
        end
        lamp_test = 1'b0; blank = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        num = 4'd11;
        tick();
        num = 4'd1;
        #2 rst_n = 1'b0;
        err_m = 1'b0;
        #1;
        tests++;
        if (err_ah !== 1'b0 || err_al !== 1'b0) begin
            $display("FAIL async_rst_err got %b/%b exp 0", err_ah, err_al); fails++;
        end
        tests++;
        if (seg_ah !== 7'b0000110 || seg_al !== 7'b1111001) begin
            $display("FAIL async_rst_seg got %b/%b exp 0000110/1111001", seg_ah, seg_al); fails++;
        end
        num = 4'd15;
        tick();
        num = 4'd1;
        #1;
        tests++;
        if (err_ah !== 1'b0 || seg_ah !== 7'b0000110) begin
            $display("FAIL in_rst got err=%b seg=%b exp 0 0000110", err_ah, seg_ah); fails++;
        end
        #2 rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_err_sequence();
        test_priority();
        test_active_low();
        test_upper_codes();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
